neuron_lut_loader: RTL and testbench
====================================

// Module: neuron_lut_loader
// PURPOSE
//  Runtime-writable counterpart of the fixed neuron truth-table ROMs.
//  - Write side: accepts a packed table stream and stores 2^IN_BITS entries of OUT_BITS each
//    in distributed RAM.
//  - Read side: serves neuron lookups from the stored table.
//  - Lets a layer's neuron functions be reprogrammed after synthesis without regenerating RTL.
// PARAMETERS
//  IN_BITS   8  lookup address width (concatenated quantised fan-in)
//  OUT_BITS  2  width of one table entry (quantised activation)
//  PACK      4  table entries per load beat; must divide 2^IN_BITS
// PORTS
//  clk        in   1                clock, all logic on rising edge
//  rst_n      in   1                synchronous reset, active low
//  load_start in   1                pulse: discard table, begin (re)load
//  s_valid    in   1                load beat valid
//  s_ready    out  1                load beat ready
//  s_data     in   OUT_BITS*PACK    load beat, entry k in bits [k*OUT_BITS +: OUT_BITS]
//  s_last     in   1                marks final beat of table
//  in_valid   in   1                lookup request valid
//  in_ready   out  1                lookup accepted (table loaded)
//  in_addr    in   IN_BITS          lookup address (same packing as ROM neuron input)
//  out_valid  out  1                lookup result valid
//  out_data   out  OUT_BITS         table[in_addr]
//  loaded     out  1                complete table present
//  load_err   out  1                sticky: last load aborted on framing error
// BEHAVIOUR
//  - States: IDLE, LOAD, READY. Reset -> IDLE.
//    Registers reset: beat counter=0, out_valid=0, out_data=0, loaded=0, load_err=0.
//    Table RAM is not reset.
//  - BEATS = 2^IN_BITS/PACK (64 at defaults). Beat b entry k is written to address b*PACK+k.
//  - s_ready = (state==LOAD) && !load_start. A beat transfers when s_valid && s_ready.
//  - in_ready = (state==READY) && !load_start. loaded = (state==READY).
//  - IDLE: load_start -> LOAD; beat counter=0, load_err cleared.
//  - LOAD: each transfer writes PACK entries and increments the counter.
//    - Transfer on beat BEATS-1 with s_last=1 -> READY.
//    - s_last=1 on beat < BEATS-1, or beat BEATS-1 with s_last=0 -> IDLE, load_err=1.
//      Entries written before the error remain in RAM but are unusable (loaded=0).
//    - load_start in LOAD restarts: counter=0, same-cycle beat not accepted.
//  - READY:
//    - Lookup transfers when in_valid && in_ready.
//    - Next cycle: out_valid=1, out_data=table[in_addr] (latency 1, registered).
//    - Otherwise out_valid=0; out_data holds its last value.
//    - No backpressure on the output side; one lookup per cycle sustained.
//    - load_start -> LOAD, counter=0, loaded drops next cycle.
//      A lookup presented in the same cycle is not accepted.
//      A result already in flight still emerges with out_valid=1 from the old table.
//  - load_start while LOAD is in progress and s_valid held high: no beat is lost or duplicated
//    beyond the restart.
//  - rst_n low mid-load or mid-lookup: synchronous return to IDLE on that edge.
//    Any pending out_valid is cleared.
//  - Counter width clog2(BEATS); never wraps (terminates at BEATS-1).
// TESTING
//  1. Reset, then lookup with in_valid=1 -> in_ready=0, out_valid stays 0, loaded=0.
//  2. Load the table with 0b01 at addresses 0x3F, 0x7F, 0xBF and 0b00 elsewhere
//     (64 beats, s_last on beat 63).
//     -> loaded=1 on the cycle after the last transfer.
//     Lookups 0x3F, 0xFF, 0x7F back-to-back -> out_data 01, 00, 01, each one cycle later.
//  3. Load with s_last on beat 10 -> load_err=1, state IDLE, in_ready=0.
//     Next full load clears load_err.
//  4. Load with s_valid toggling randomly (50%) -> all 256 entries match the reference array
//     on an exhaustive readback.
//  5. In READY, assert load_start with in_valid=1 in the same cycle
//     -> that lookup is not accepted; the earlier in-flight result is still delivered.
//     Reload with the inverted table -> readback returns the new values.
//  6. rst_n low at beat 30 of a load -> IDLE, loaded=0.
//     A fresh complete load then succeeds.

Source files
------------

// File: rtl/neuron_lut_loader.sv
// Runtime-loadable neuron truth table: a packed beat stream fills a distributed RAM,
// then single-cycle registered lookups are served from it.
module neuron_lut_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int PACK     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [OUT_BITS*PACK-1:0] s_data,
    input  logic                     s_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_BITS-1:0]       in_addr,
    output logic                     out_valid,
    output logic [OUT_BITS-1:0]      out_data,
    output logic                     loaded,
    output logic                     load_err
);

    localparam int DEPTH = 2 ** IN_BITS;
    localparam int BEATS = DEPTH / PACK;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       beat;
    logic [OUT_BITS-1:0] mem [DEPTH];
    logic                xfer, last_beat, lookup;

    assign s_ready   = (state == LOAD) && !load_start;
    assign in_ready  = (state == READY) && !load_start;
    assign loaded    = (state == READY);
    assign xfer      = s_valid && s_ready;
    assign last_beat = (beat == CW'(BEATS - 1));
    assign lookup    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (load_start) state_nxt = LOAD;
            // s_last and the final beat must coincide; any mismatch aborts the load
            LOAD:  if (xfer && (s_last || last_beat))
                       state_nxt = (s_last && last_beat) ? READY : IDLE;
            READY: if (load_start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat      <= '0;
            load_err  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (load_start) begin
                beat     <= '0;
                load_err <= 1'b0;
            end else if (xfer) begin
                if (s_last || last_beat) begin
                    if (!(s_last && last_beat)) load_err <= 1'b1;
                end else begin
                    beat <= beat + 1'b1;
                end
            end
            out_valid <= lookup;
            if (lookup) out_data <= mem[in_addr];
        end
    end

    // Table storage has no reset so it maps onto LUT RAM
    always_ff @(posedge clk) begin
        if (xfer && rst_n) begin
            for (int k = 0; k < PACK; k++)
                mem[IN_BITS'(int'(beat) * PACK + k)] <= s_data[k*OUT_BITS +: OUT_BITS];
        end
    end

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Scoreboard bench for neuron_lut_loader: an array-based table model predicts lookups,
// and a negedge monitor pops expected results whenever out_valid is seen.
module tb_neuron_lut_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_addr = '0;
    logic       out_valid;
    logic [1:0] out_data;
    logic       loaded;
    logic       load_err;

    neuron_lut_loader #(.IN_BITS(8), .OUT_BITS(2), .PACK(4)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .out_valid(out_valid), .out_data(out_data),
        .loaded(loaded), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] d;
        logic [7:0] a;
        int         cyc;
    } exp_t;

    exp_t       sbq[$];
    logic [1:0] stim  [256];
    logic [1:0] m_tbl [256];
    bit         m_loaded = 0;
    bit         m_err = 0;
    int         n_pass = 0;
    int         n_total = 0;

    function automatic void chk(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk($sformatf("out_data[%02h]", e.a), out_data, e.d);
                chk("lookup_latency", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [7:0] a);
        in_valid = 1'b1;
        in_addr  = a;
        #1;
        chk("in_ready", in_ready, m_loaded);
        if (m_loaded) sbq.push_back('{d: m_tbl[a], a: a, cyc: cyc + 1});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic readback();
        for (int a = 0; a < 256; a++) lookup(8'(a));
    endtask

    // last_at: beat carrying s_last; rst_at: pull reset at that beat; rs_at: restart there
    task automatic load_tbl(input int last_at, input bit rnd, input bit do_start,
                            input int rst_at, input int rs_at);
        int  b = 0;
        int  guard = 0;
        bit  restarted = 0;
        if (do_start) begin
            load_start = 1'b1;
            tick();
            load_start = 1'b0;
        end
        m_loaded = 0;
        m_err    = 0;
        while (b <= last_at && guard < 5000) begin
            if (b == rst_at) begin
                rst_n   = 1'b0;
                s_valid = 1'b1;
                tick();
                rst_n   = 1'b1;
                s_valid = 1'b0;
                return;
            end
            for (int k = 0; k < 4; k++) s_data[k*2 +: 2] = stim[b*4 + k];
            s_last = (b == last_at);
            if (b == rs_at && !restarted) begin
                restarted  = 1;
                load_start = 1'b1;
                s_valid    = 1'b1;
                #1;
                chk("s_ready_on_restart", s_ready, 0);
                tick();
                load_start = 1'b0;
                b = 0;
                continue;
            end
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk("s_ready", s_ready, 1);
            if (s_valid) b++;
            tick();
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (guard >= 5000) chk("load_timeout", 0, 1);
        if (last_at == 255 / 4) begin
            m_loaded = 1;
            m_tbl    = stim;
        end else begin
            m_err = 1;
        end
        chk("loaded_after_load", loaded, m_loaded);
        chk("load_err_after_load", load_err, m_err);
        chk("in_ready_after_load", in_ready, m_loaded);
    endtask

    task automatic rand_stim();
        for (int i = 0; i < 256; i++) stim[i] = 2'($urandom);
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_s_ready", s_ready, 0);

        // 1: lookups before any table must be refused
        for (int i = 0; i < 4; i++) lookup(8'(i * 7));
        chk("t1_loaded", loaded, 0);

        // 2: sparse table, back-to-back lookups
        for (int i = 0; i < 256; i++) stim[i] = 2'b00;
        stim[8'h3F] = 2'b01;
        stim[8'h7F] = 2'b01;
        stim[8'hBF] = 2'b01;
        load_tbl(63, 0, 1, -1, -1);
        lookup(8'h3F);
        lookup(8'hFF);
        lookup(8'h7F);
        tick();

        // 3: premature s_last aborts, next full load clears the error
        rand_stim();
        load_tbl(10, 0, 1, -1, -1);
        lookup(8'h05);
        load_tbl(63, 0, 1, -1, -1);
        lookup(8'h05);

        // 4: random table with gappy s_valid, exhaustive readback
        rand_stim();
        load_tbl(63, 1, 1, -1, -1);
        readback();

        // 5: load_start collides with a lookup while a result is in flight
        lookup(8'h42);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_addr    = 8'h43;
        #1;
        chk("t5_in_ready_blocked", in_ready, 0);
        chk("t5_s_ready_blocked", s_ready, 0);
        tick();
        load_start = 1'b0;
        in_valid   = 1'b0;
        m_loaded   = 0;
        chk("t5_loaded_drop", loaded, 0);
        for (int i = 0; i < 256; i++) stim[i] = ~stim[i];
        load_tbl(63, 0, 0, -1, -1);
        readback();

        // restart mid-load with s_valid held high
        rand_stim();
        load_tbl(63, 0, 1, -1, 20);
        readback();

        // 6: reset during beat 30, then a fresh load
        rand_stim();
        load_tbl(63, 0, 1, 30, -1);
        m_loaded = 0;
        m_err    = 0;
        chk("t6_loaded", loaded, 0);
        chk("t6_load_err", load_err, 0);
        chk("t6_in_ready", in_ready, 0);
        rand_stim();
        load_tbl(63, 1, 1, -1, -1);
        readback();

        repeat (4) tick();
        chk("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
